// File: rtl/wired_fpu_share_arb_pkg.sv
// wired_fpu_share_arb_pkg: shared FPU issue/response types and tag sizing for the shared fpnew path
package wired_fpu_share_arb_pkg;
  localparam int FPU_TAG_NUM = 4;
  localparam int FPU_TAG_W = $clog2(FPU_TAG_NUM);
  typedef logic [FPU_TAG_W-1:0] fpu_tag_t;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_excp_t;
  typedef struct packed {
    logic [3:0]  op;
    logic        mode;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  wid;
  } iq_fpu_req_t;
  typedef struct packed {
    logic [5:0]  wid;
    logic [31:0] result;
    fp_excp_t    fp_excp;
  } iq_fpu_resp_t;
endpackage

// File: rtl/wired_tag_alloc.sv
// wired_tag_alloc: in-flight tag bookkeeping (free/stale bitmaps, owner table, lowest-free pick, busy count)
module wired_tag_alloc #(
  parameter int N_REQ = 2,
  parameter int TAG_NUM = 4,
  parameter int TAG_W = $clog2(TAG_NUM),
  parameter int OW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_i,
  input  logic [OW-1:0]    alloc_owner_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  input  logic             flush_i,
  input  logic             kill_i,
  input  logic [TAG_W-1:0] kill_tag_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             any_free_o,
  output logic [TAG_W-1:0] free_tag_o,
  output logic [OW-1:0]    lookup_owner_o,
  output logic             lookup_live_o,
  output logic             lookup_busy_o,
  output logic [TAG_W:0]   busy_cnt_o
);
  logic [TAG_NUM-1:0] busy_q, busy_d, stale_q, stale_d;
  logic [OW-1:0] owner_q [TAG_NUM];
  always_comb begin
    any_free_o = ~&busy_q;
    free_tag_o = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) if (!busy_q[i]) free_tag_o = TAG_W'(i);
    busy_d = busy_q;
    stale_d = stale_q;
    if (free_i) begin
      busy_d[free_tag_i] = 1'b0;
      stale_d[free_tag_i] = 1'b0;
    end
    // Everything still out in fpnew at flush time must be dropped when it returns.
    if (flush_i) stale_d = stale_d | busy_d;
    if (kill_i) begin
      busy_d[kill_tag_i] = 1'b0;
      stale_d[kill_tag_i] = 1'b0;
    end
    if (alloc_i) busy_d[free_tag_o] = 1'b1;
    busy_cnt_o = '0;
    for (int i = 0; i < TAG_NUM; i++) busy_cnt_o = busy_cnt_o + (TAG_W + 1)'(busy_q[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      stale_q <= '0;
    end else begin
      busy_q <= busy_d;
      stale_q <= stale_d;
    end
  end
  always_ff @(posedge clk) if (alloc_i) owner_q[free_tag_o] <= alloc_owner_i;
  assign lookup_owner_o = owner_q[lookup_tag_i];
  assign lookup_busy_o = busy_q[lookup_tag_i];
  assign lookup_live_o = busy_q[lookup_tag_i] & ~stale_q[lookup_tag_i];
endmodule

// File: rtl/wired_fpu_share_arb.sv
// wired_fpu_share_arb: round-robin sharing of one fpnew between FPU issue queues,
// with tagged out-of-order result routing and flush of in-flight ops.
module wired_fpu_share_arb
  import wired_fpu_share_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_NUM = FPU_TAG_NUM,
  parameter int TAG_W = $clog2(TAG_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [N_REQ-1:0] req_valid_i,
  output logic [N_REQ-1:0] req_ready_o,
  input  iq_fpu_req_t      req_i [N_REQ],
  output logic             fpu_valid_o,
  input  logic             fpu_ready_i,
  output iq_fpu_req_t      fpu_req_o,
  output logic [TAG_W-1:0] fpu_tag_o,
  input  logic             fpu_valid_i,
  output logic             fpu_ready_o,
  input  iq_fpu_resp_t     fpu_resp_i,
  input  logic [TAG_W-1:0] fpu_tag_i,
  output logic [N_REQ-1:0] resp_valid_o,
  input  logic [N_REQ-1:0] resp_ready_i,
  output iq_fpu_resp_t     resp_o,
  output logic [TAG_W:0]   busy_cnt_o
);
  localparam int OW = $clog2(N_REQ);
  logic valid_q, valid_d, gnt, any_free, live, tag_busy, resp_ok, free, kill;
  iq_fpu_req_t req_q, req_d;
  logic [TAG_W-1:0] tag_q, tag_d, free_tag;
  logic [OW-1:0] rr_q, rr_d, gnt_idx, owner;
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    // Scan downwards so the requester closest to rr_q wins.
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid_i[(int'(rr_q) + k) % N_REQ]) begin
        gnt = 1'b1;
        gnt_idx = OW'((int'(rr_q) + k) % N_REQ);
      end
    gnt = gnt & (~valid_q | fpu_ready_i) & any_free & ~flush_i & rst_n;
    req_ready_o = gnt ? N_REQ'(1) << gnt_idx : '0;
    valid_d = flush_i ? 1'b0 : gnt ? 1'b1 : valid_q & ~fpu_ready_i;
    req_d = gnt ? req_i[gnt_idx] : req_q;
    tag_d = gnt ? free_tag : tag_q;
    rr_d = gnt ? OW'((int'(gnt_idx) + 1) % N_REQ) : rr_q;
    kill = flush_i & valid_q & ~fpu_ready_i;
    resp_ok = live & ~flush_i;
    fpu_ready_o = resp_ok ? resp_ready_i[owner] : 1'b1;
    resp_valid_o = (resp_ok & fpu_valid_i) ? N_REQ'(1) << owner : '0;
    free = fpu_valid_i & fpu_ready_o;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rr_q <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q <= rr_d;
    end
    req_q <= req_d;
    tag_q <= tag_d;
  end
  wired_tag_alloc #(.N_REQ(N_REQ), .TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .OW(OW)) u_tag_alloc (
    .clk(clk), .rst_n(rst_n), .alloc_i(gnt), .alloc_owner_i(gnt_idx),
    .free_i(free), .free_tag_i(fpu_tag_i), .flush_i(flush_i), .kill_i(kill), .kill_tag_i(tag_q),
    .lookup_tag_i(fpu_tag_i), .any_free_o(any_free), .free_tag_o(free_tag),
    .lookup_owner_o(owner), .lookup_live_o(live), .lookup_busy_o(tag_busy), .busy_cnt_o(busy_cnt_o)
  );
  assign fpu_valid_o = valid_q;
  assign fpu_req_o = req_q;
  assign fpu_tag_o = tag_q;
  assign resp_o = fpu_resp_i;
  a_resp_tag_allocated: assert property (@(posedge clk) disable iff (!rst_n) fpu_valid_i |-> tag_busy);
endmodule

// File: tb/tb_wired_fpu_share_arb.sv
// tb_wired_fpu_share_arb: directed scenarios plus random traffic checked against a behavioural tag/issue model
module tb_wired_fpu_share_arb;
  import wired_fpu_share_arb_pkg::*;
  localparam int N = 2;
  localparam int T = 4;
  logic clk = 0, rst_n = 0, flush_i = 0, fpu_ready_i = 0, fpu_valid_i = 0;
  logic fpu_valid_o, fpu_ready_o;
  logic [N-1:0] req_valid_i = '0, resp_ready_i = '0, req_ready_o, resp_valid_o;
  iq_fpu_req_t req_i [N];
  iq_fpu_req_t fpu_req_o;
  iq_fpu_resp_t fpu_resp_i, resp_o;
  logic [1:0] fpu_tag_i = '0, fpu_tag_o;
  logic [2:0] busy_cnt_o;
  always #5 clk = ~clk;
  wired_fpu_share_arb #(.N_REQ(N), .TAG_NUM(T)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_i(req_i), .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_req_o(fpu_req_o),
    .fpu_tag_o(fpu_tag_o), .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_resp_i(fpu_resp_i),
    .fpu_tag_i(fpu_tag_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .busy_cnt_o(busy_cnt_o)
  );
  int n_cmp = 0, n_fail = 0;
  bit m_busy [T], m_stale [T], in_fpu [T];
  int m_owner [T];
  iq_fpu_req_t fop [T];
  int m_rr = 0, m_itag = 0;
  bit m_iv = 0;
  iq_fpu_req_t m_ireq;
  logic [N-1:0] s_rdy, s_rv;
  logic s_fr;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input bit rnd);
    int q[$];
    for (int t = 0; t < T; t++) if (in_fpu[t]) q.push_back(t);
    if (q.size() == 0) return -1;
    return rnd ? q[$urandom_range(0, q.size() - 1)] : q[0];
  endfunction
  task automatic step(input bit rn, input bit fls, input logic [N-1:0] rv, input bit fr, input int ret,
                      input logic [N-1:0] rr);
    int g, tnew, ft, cnt;
    bit slot, anyf, live, e_fr;
    logic [N-1:0] e_rdy, e_rv;
    iq_fpu_resp_t e_resp;
    rst_n = rn;
    flush_i = fls;
    req_valid_i = rv;
    fpu_ready_i = fr;
    resp_ready_i = rr;
    for (int i = 0; i < N; i++) begin
      req_i[i].op = 4'($urandom);
      req_i[i].mode = 1'($urandom);
      req_i[i].r0 = $urandom;
      req_i[i].r1 = $urandom;
      req_i[i].r2 = $urandom;
      req_i[i].wid = 6'($urandom);
    end
    ft = ret < 0 ? 0 : ret;
    fpu_valid_i = ret >= 0;
    fpu_tag_i = 2'(ft);
    fpu_resp_i.wid = fop[ft].wid;
    fpu_resp_i.result = fop[ft].r0 ^ fop[ft].r1;
    fpu_resp_i.fp_excp = 5'($urandom);
    #3;
    slot = !m_iv || fr;
    anyf = 0;
    tnew = -1;
    for (int t = T - 1; t >= 0; t--) if (!m_busy[t]) begin anyf = 1; tnew = t; end
    g = -1;
    if (rn && slot && anyf && !fls)
      for (int k = N - 1; k >= 0; k--) if (rv[(m_rr + k) % N]) g = (m_rr + k) % N;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    live = m_busy[ft] && !m_stale[ft] && !fls;
    e_fr = live ? rr[m_owner[ft]] : 1'b1;
    e_rv = '0;
    if (live && ret >= 0) e_rv[m_owner[ft]] = 1'b1;
    cnt = 0;
    for (int t = 0; t < T; t++) cnt += int'(m_busy[t]);
    s_rdy = req_ready_o;
    s_rv = resp_valid_o;
    s_fr = fpu_ready_o;
    if (rn) begin
      chk("fpu_valid_o", fpu_valid_o, m_iv);
      if (m_iv) begin
        chk("fpu_req_o", fpu_req_o, m_ireq);
        chk("fpu_tag_o", fpu_tag_o, m_itag);
      end
      chk("req_ready_o", req_ready_o, e_rdy);
      chk("fpu_ready_o", fpu_ready_o, e_fr);
      chk("resp_valid_o", resp_valid_o, e_rv);
      chk("busy_cnt_o", busy_cnt_o, cnt);
      if (e_rv != 0) begin
        e_resp.wid = fop[ft].wid;
        e_resp.result = fop[ft].r0 ^ fop[ft].r1;
        e_resp.fp_excp = fpu_resp_i.fp_excp;
        chk("resp_o", resp_o, e_resp);
      end
    end
    if (!rn) begin
      for (int t = 0; t < T; t++) begin m_busy[t] = 0; m_stale[t] = 0; in_fpu[t] = 0; end
      m_rr = 0;
      m_iv = 0;
    end else begin
      if (m_iv && fr) begin in_fpu[m_itag] = 1; fop[m_itag] = m_ireq; end
      if (ret >= 0 && e_fr) begin m_busy[ft] = 0; m_stale[ft] = 0; in_fpu[ft] = 0; end
      if (fls) begin
        for (int t = 0; t < T; t++) if (m_busy[t]) m_stale[t] = 1;
        if (m_iv && !fr) begin m_busy[m_itag] = 0; m_stale[m_itag] = 0; end
        m_iv = 0;
      end else if (g >= 0) begin
        m_busy[tnew] = 1;
        m_owner[tnew] = g;
        m_iv = 1;
        m_ireq = req_i[g];
        m_itag = tnew;
        m_rr = (g + 1) % N;
      end else if (fr) m_iv = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    step(0, 0, 2'b11, 1, -1, 2'b11);
    step(0, 0, 2'b11, 1, -1, 2'b11);
    chk("reset req_ready_o", s_rdy, 2'b00);
    chk("reset fpu_valid_o", fpu_valid_o, 1'b0);
    chk("reset busy_cnt_o", busy_cnt_o, 3'd0);
  endtask
  initial begin
    logic [N-1:0] alt [4];
    alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;
    #1;
    do_reset();
    // round-robin alternation with immediate returns
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 2'b11, 1, pick(0), 2'b11);
      if (i < 4) chk("rr alternation", s_rdy, alt[i]);
    end
    // fill all tags, then out-of-order returns with backpressure
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 2'b11, 1, -1, 2'b11);
    step(1, 0, 2'b11, 1, -1, 2'b11);
    chk("full req_ready_o", s_rdy, 2'b00);
    chk("full busy_cnt_o", busy_cnt_o, 3'd4);
    step(1, 0, 2'b00, 1, 3, 2'b11);
    chk("ret tag3 resp_valid", s_rv, 2'b10);
    step(1, 0, 2'b00, 1, 0, 2'b11);
    chk("ret tag0 resp_valid", s_rv, 2'b01);
    step(1, 0, 2'b00, 1, 2, 2'b11);
    chk("ret tag2 resp_valid", s_rv, 2'b01);
    step(1, 0, 2'b00, 1, 1, 2'b01);
    chk("held fpu_ready_o", s_fr, 1'b0);
    chk("held resp_valid", s_rv, 2'b10);
    step(1, 0, 2'b00, 1, 1, 2'b11);
    chk("release fpu_ready_o", s_fr, 1'b1);
    chk("drained busy_cnt_o", busy_cnt_o, 3'd0);
    // flush with 3 in flight and 1 in the issue register
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 2'b01, 1, -1, 2'b11);
    step(1, 1, 2'b01, 0, -1, 2'b11);
    chk("flush req_ready_o", s_rdy, 2'b00);
    chk("flush fpu_valid_o", fpu_valid_o, 1'b0);
    chk("flush busy_cnt_o", busy_cnt_o, 3'd3);
    for (int t = 0; t < 3; t++) begin
      step(1, 0, 2'b00, 0, t, 2'b11);
      chk("stale resp_valid", s_rv, 2'b00);
      chk("stale fpu_ready_o", s_fr, 1'b1);
    end
    chk("stale drained busy_cnt_o", busy_cnt_o, 3'd0);
    // issue stall
    do_reset();
    step(1, 0, 2'b11, 1, -1, 2'b11);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 2'b11, 0, -1, 2'b11);
      chk("stall req_ready_o", s_rdy, 2'b00);
      chk("stall fpu_tag_o", fpu_tag_o, 2'd0);
    end
    step(1, 0, 2'b11, 1, -1, 2'b11);
    chk("post-stall grant", s_rdy, 2'b10);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 39) == 0, 2'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6 ? pick(1) : -1, {$urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
